// File: rtl/vpu_test_pkg.sv
// Shared types and ASCII helpers for the VPU self-test UART reporter.
package vpu_test_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StCapture,
    StLoad,
    StSend,
    StNext,
    StDone
  } rpt_state_t;

  typedef enum logic {
    MSG_PASS,
    MSG_FAIL
  } msg_kind_t;

  localparam logic [7:0] CHR_SPACE = 8'h20;
  localparam logic [7:0] CHR_CR    = 8'h0D;
  localparam logic [7:0] CHR_LF    = 8'h0A;

  // Uppercase hex digit: 0x30 + n for 0-9, 0x41 + (n - 10) for A-F.
  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    if (nib < 4'd10) begin
      return 8'h30 + {4'h0, nib};
    end
    return 8'h37 + {4'h0, nib};
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// UART 8N1 byte transmitter: start bit, 8 data bits LSB first, stop bit.
module uart_tx_byte #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       clk_100mhz,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);

  logic [CntW-1:0] cnt_q;
  logic [3:0]      bit_q;
  logic [7:0]      shreg_q;
  logic            tx_q;
  logic            busy_q;
  logic            bit_end;

  assign bit_end = busy_q && (cnt_q == CntLast);
  assign done    = bit_end && (bit_q == 4'd9);
  assign tx      = tx_q;
  assign busy    = busy_q;

  // bit_q: 0 = start, 1..8 = data, 9 = stop.
  always_ff @(posedge clk_100mhz or posedge rst) begin
    if (rst) begin
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
    end else if (!busy_q) begin
      if (start) begin
        busy_q  <= 1'b1;
        tx_q    <= 1'b0;
        cnt_q   <= '0;
        bit_q   <= '0;
        shreg_q <= data;
      end
    end else if (bit_end) begin
      cnt_q <= '0;
      if (bit_q == 4'd9) begin
        busy_q <= 1'b0;
        bit_q  <= '0;
        tx_q   <= 1'b1;
      end else begin
        bit_q <= bit_q + 4'd1;
        if (bit_q < 4'd8) begin
          tx_q    <= shreg_q[0];
          shreg_q <= {1'b0, shreg_q[7:1]};
        end else begin
          tx_q <= 1'b1;
        end
      end
    end else begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

endmodule

// File: rtl/vpu_test_uart_reporter.sv
// Sends one ASCII PASS/FAIL report over UART when the self-test reaches a terminal status.
module vpu_test_uart_reporter
  import vpu_test_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned DATA_W       = 32
) (
  input  logic              clk_100mhz,
  input  logic              rst,
  input  logic              pass_i,
  input  logic              fail_i,
  input  logic [7:0]        test_num_i,
  input  logic [7:0]        tests_passed_i,
  input  logic [DATA_W-1:0] result_i,
  input  logic [DATA_W-1:0] golden_i,
  output logic              uart_tx_o,
  output logic              busy_o,
  output logic              sent_o
);

  localparam int unsigned NibW      = DATA_W / 4;
  localparam int unsigned PassBytes = 9;
  localparam int unsigned FailBytes = 11 + 2 * NibW;
  localparam int unsigned IdxW      = $clog2(FailBytes);

  rpt_state_t        state_q, state_d;
  msg_kind_t         kind_q;
  logic              prev_q;
  logic              ev;
  logic [7:0]        test_num_q, tests_passed_q;
  logic [DATA_W-1:0] result_q, golden_q;
  logic [IdxW-1:0]   byte_idx_q, byte_idx_d;
  logic [IdxW-1:0]   last_idx;
  logic [7:0]        cur_byte;
  logic [DATA_W-1:0] nib_src;
  int unsigned       idx;
  logic              tx_start, tx_busy, tx_done;

  assign ev       = pass_i | fail_i;
  assign last_idx = (kind_q == MSG_FAIL) ? IdxW'(FailBytes - 1) : IdxW'(PassBytes - 1);

  always_ff @(posedge clk_100mhz or posedge rst) begin
    if (rst) begin
      state_q        <= StIdle;
      prev_q         <= 1'b0;
      byte_idx_q     <= '0;
      kind_q         <= MSG_PASS;
      test_num_q     <= '0;
      tests_passed_q <= '0;
      result_q       <= '0;
      golden_q       <= '0;
    end else begin
      state_q    <= state_d;
      prev_q     <= ev;
      byte_idx_q <= byte_idx_d;
      if (state_q == StCapture) begin
        kind_q         <= fail_i ? MSG_FAIL : MSG_PASS;
        test_num_q     <= test_num_i;
        tests_passed_q <= tests_passed_i;
        result_q       <= result_i;
        golden_q       <= golden_i;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    tx_start   = 1'b0;
    unique case (state_q)
      StIdle:    if (ev && !prev_q) state_d = StCapture;
      StCapture: begin
        byte_idx_d = '0;
        state_d    = StLoad;
      end
      StLoad: begin
        if (!tx_busy) begin
          tx_start = 1'b1;
          state_d  = StSend;
        end
      end
      StSend:    if (tx_done) state_d = StNext;
      StNext: begin
        if (byte_idx_q == last_idx) begin
          state_d = StDone;
        end else begin
          byte_idx_d = byte_idx_q + IdxW'(1);
          state_d    = StLoad;
        end
      end
      StDone:    state_d = StDone;
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    busy_o = (state_q == StCapture) || (state_q == StLoad) ||
             (state_q == StSend) || (state_q == StNext);
    sent_o = (state_q == StDone);
  end

  // Message byte at byte_idx; the FAIL layout is
  // "FAIL tt rrrr.. gggg..\r\n", the PASS layout "PASS pp\r\n".
  always_comb begin
    idx      = {{(32 - IdxW){1'b0}}, byte_idx_q};
    nib_src  = '0;
    cur_byte = CHR_SPACE;
    if (idx == 0) begin
      cur_byte = (kind_q == MSG_FAIL) ? "F" : "P";
    end else if (idx == 1) begin
      cur_byte = "A";
    end else if (idx == 2) begin
      cur_byte = (kind_q == MSG_FAIL) ? "I" : "S";
    end else if (idx == 3) begin
      cur_byte = (kind_q == MSG_FAIL) ? "L" : "S";
    end else if (idx == 4) begin
      cur_byte = CHR_SPACE;
    end else if (idx == 5) begin
      cur_byte = hex_ascii((kind_q == MSG_FAIL) ? test_num_q[7:4] : tests_passed_q[7:4]);
    end else if (idx == 6) begin
      cur_byte = hex_ascii((kind_q == MSG_FAIL) ? test_num_q[3:0] : tests_passed_q[3:0]);
    end else if (kind_q == MSG_PASS) begin
      cur_byte = (idx == 7) ? CHR_CR : CHR_LF;
    end else if (idx == 7) begin
      cur_byte = CHR_SPACE;
    end else if (idx < 8 + NibW) begin
      nib_src  = result_q >> (4 * (NibW - 1 - (idx - 8)));
      cur_byte = hex_ascii(nib_src[3:0]);
    end else if (idx == 8 + NibW) begin
      cur_byte = CHR_SPACE;
    end else if (idx < 9 + 2 * NibW) begin
      nib_src  = golden_q >> (4 * (NibW - 1 - (idx - 9 - NibW)));
      cur_byte = hex_ascii(nib_src[3:0]);
    end else if (idx == 9 + 2 * NibW) begin
      cur_byte = CHR_CR;
    end else begin
      cur_byte = CHR_LF;
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk_100mhz(clk_100mhz),
    .rst       (rst),
    .start     (tx_start),
    .data      (cur_byte),
    .tx        (uart_tx_o),
    .busy      (tx_busy),
    .done      (tx_done)
  );

endmodule

// File: tb/tb_vpu_test_uart_reporter.sv
// Bench for vpu_test_uart_reporter: mid-bit UART decoder feeding a byte scoreboard.
module tb_vpu_test_uart_reporter;

  localparam int CPB = 4;
  localparam int DW  = 32;

  typedef struct {
    logic        do_pass;
    logic        do_fail;
    logic [7:0]  tn;
    logic [7:0]  tp;
    logic [31:0] res;
    logic [31:0] gold;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic pass_i, fail_i;
  logic [7:0] test_num, tests_passed;
  logic [DW-1:0] result, golden;
  logic uart_tx, busy, sent;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  int rx_cnt = 0;
  vec_t vecs[4];

  always #5 clk = ~clk;

  vpu_test_uart_reporter #(
    .CLKS_PER_BIT(CPB),
    .DATA_W      (DW)
  ) dut (
    .clk_100mhz    (clk),
    .rst           (rst),
    .pass_i        (pass_i),
    .fail_i        (fail_i),
    .test_num_i    (test_num),
    .tests_passed_i(tests_passed),
    .result_i      (result),
    .golden_i      (golden),
    .uart_tx_o     (uart_tx),
    .busy_o        (busy),
    .sent_o        (sent)
  );

  function automatic void check(input bit ok, input string name, input longint act,
                                input longint req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endfunction

  function automatic logic [7:0] hexc(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    return 8'h41 + {4'h0, n} - 8'd10;
  endfunction

  function automatic void push_str(input string s);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
  endfunction

  function automatic void push_hex(input logic [31:0] v, input int digits);
    for (int i = digits - 1; i >= 0; i--) begin
      logic [31:0] t;
      t = v >> (4 * i);
      exp_q.push_back(hexc(t[3:0]));
    end
  endfunction

  function automatic int push_expected(input vec_t v);
    if (v.do_fail) begin
      push_str("FAIL ");
      push_hex({24'h0, v.tn}, 2);
      push_str(" ");
      push_hex(v.res, 8);
      push_str(" ");
      push_hex(v.gold, 8);
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
      return 27;
    end
    push_str("PASS ");
    push_hex({24'h0, v.tp}, 2);
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
    return 9;
  endfunction

  // Line decoder: samples on the falling edge, i.e. mid-cycle of each bit cycle.
  initial begin
    int d_state, d_bit, d_cnt, gap;
    bit gap_valid, hold_bad;
    logic d_lvl;
    logic [7:0] d_data, e;
    d_state = 0; d_bit = 0; d_cnt = 0; gap = 0; gap_valid = 0; hold_bad = 0;
    d_lvl = 1'b1; d_data = '0;
    forever begin
      @(negedge clk);
      if (rst !== 1'b0) begin
        d_state = 0;
        gap_valid = 0;
      end else if (d_state == 0) begin
        if (uart_tx === 1'b0) begin
          if (gap_valid) check(gap == 2, "interbyte_gap", gap, 2);
          d_state = 1; d_bit = 0; d_cnt = 1; d_lvl = 1'b0; hold_bad = 0;
        end else if (gap_valid) begin
          gap++;
        end
      end else begin
        if (d_cnt == CPB) begin
          d_bit++;
          d_cnt = 1;
          d_lvl = uart_tx;
          if (d_bit >= 1 && d_bit <= 8) d_data[d_bit-1] = uart_tx;
        end else begin
          d_cnt++;
          if (uart_tx !== d_lvl) hold_bad = 1;
        end
        if (d_bit == 9 && d_cnt == CPB) begin
          check(!hold_bad, "bit_hold", hold_bad, 0);
          check(d_lvl === 1'b1, "stop_bit", d_lvl, 1);
          rx_cnt++;
          if (exp_q.size() == 0) begin
            check(0, "unexpected_byte", d_data, 0);
          end else begin
            e = exp_q.pop_front();
            check(d_data == e, "rx_byte", d_data, e);
          end
          d_state = 0; gap = 0; gap_valid = 1;
        end
      end
    end
  end

  task automatic run_vector(input vec_t v, input string tag);
    int n, cyc, rx0;
    bit busy_bad;
    n = push_expected(v);
    rx0 = rx_cnt;
    @(posedge clk); #1;
    test_num = v.tn; tests_passed = v.tp; result = v.res; golden = v.gold;
    pass_i = v.do_pass; fail_i = v.do_fail;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check(uart_tx === 1'b1, {tag, "_line_idle_before_start"}, uart_tx, 1);
    @(posedge clk); #1;
    check(uart_tx === 1'b0, {tag, "_start_latency"}, uart_tx, 0);
    // Captured values must survive later input changes.
    test_num = 8'($urandom); tests_passed = 8'($urandom);
    result = $urandom; golden = $urandom;
    cyc = 0;
    busy_bad = 0;
    while (sent !== 1'b1 && cyc < 3000) begin
      if (busy !== 1'b1) busy_bad = 1;
      @(posedge clk); #1;
      cyc++;
    end
    check(sent === 1'b1, {tag, "_sent"}, sent, 1);
    check(!busy_bad, {tag, "_busy_during_report"}, busy_bad, 0);
    check(cyc >= n * (10 * CPB + 2) - 1 && cyc <= n * (10 * CPB + 2) + 1,
          {tag, "_report_time"}, cyc, n * (10 * CPB + 2));
    check(rx_cnt - rx0 == n, {tag, "_byte_count"}, rx_cnt - rx0, n);
    check(exp_q.size() == 0, {tag, "_queue_drained"}, exp_q.size(), 0);
    check(busy === 1'b0 && uart_tx === 1'b1, {tag, "_done_outputs"}, {busy, uart_tx}, 2'b01);
    // No second report after DONE.
    pass_i = 1'b0; fail_i = 1'b0;
    repeat (5) @(posedge clk);
    #1 pass_i = 1'b1;
    repeat (60) @(posedge clk);
    #1;
    check(rx_cnt - rx0 == n && sent === 1'b1 && busy === 1'b0 && uart_tx === 1'b1,
          {tag, "_no_second_report"}, rx_cnt - rx0, n);
    pass_i = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rx0, t;
    rst = 1'b1;
    pass_i = 1'b0; fail_i = 1'b0;
    test_num = '0; tests_passed = '0; result = '0; golden = '0;
    vecs[0] = '{do_pass: 1'b1, do_fail: 1'b0, tn: 8'h55, tp: 8'h0A,
                res: 32'h1111_2222, gold: 32'h3333_4444};
    vecs[1] = '{do_pass: 1'b0, do_fail: 1'b1, tn: 8'h03, tp: 8'h02,
                res: 32'hDEAD_BEEF, gold: 32'h0000_BEEF};
    vecs[2] = '{do_pass: 1'b1, do_fail: 1'b1, tn: 8'hC7, tp: 8'h11,
                res: 32'h0123_4567, gold: 32'h89AB_CDEF};
    vecs[3] = '{do_pass: 1'b1, do_fail: 1'b0, tn: 8'h00, tp: 8'hFF,
                res: 32'hFFFF_FFFF, gold: 32'h0};

    repeat (3) @(posedge clk);
    #1;
    check(uart_tx === 1'b1, "reset_tx", uart_tx, 1);
    check(busy === 1'b0, "reset_busy", busy, 0);
    check(sent === 1'b0, "reset_sent", sent, 0);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check(uart_tx === 1'b1 && busy === 1'b0 && sent === 1'b0, "idle_after_release",
          {uart_tx, busy, sent}, 3'b100);

    for (int i = 0; i < 4; i++) run_vector(vecs[i], $sformatf("vec%0d", i));

    // Reset in the middle of the sixth byte.
    t = push_expected(vecs[1]);
    rx0 = rx_cnt;
    @(posedge clk); #1;
    test_num = vecs[1].tn; result = vecs[1].res; golden = vecs[1].gold; fail_i = 1'b1;
    t = 0;
    while (rx_cnt - rx0 < 5 && t < 1000) begin
      @(posedge clk);
      t++;
    end
    check(rx_cnt - rx0 == 5, "midreset_reach_byte5", rx_cnt - rx0, 5);
    t = 0;
    while (uart_tx !== 1'b0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check(uart_tx === 1'b0, "midreset_line_low", uart_tx, 0);
    #2 rst = 1'b1;
    #1;
    check(uart_tx === 1'b1, "midreset_tx", uart_tx, 1);
    check(busy === 1'b0 && sent === 1'b0, "midreset_flags", {busy, sent}, 2'b00);
    exp_q.delete();
    fail_i = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    run_vector('{do_pass: 1'b1, do_fail: 1'b0, tn: 8'h00, tp: 8'h3C,
                 res: 32'h0, gold: 32'h0}, "after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vpu_test_uart_reporter.md
# vpu_test_uart_reporter

Serial result reporter for the FPGA VPU self-test. It watches the test top's terminal PASS/FAIL status, builds a fixed ASCII report, and sends it on a UART 8N1 transmit line, so a bench host sees the same information a simulation bench prints from internal probes. It sits beside the self-checking sequencer in the FPGA test top and drives the board's UART TX pin.

## Interface
- `CLKS_PER_BIT`, default 868: clock cycles per UART bit (115200 baud at 100 MHz); must be ≥ 2.
- `DATA_W`, default 32: width of the result and golden words; must be a multiple of 4.
- `clk_100mhz` input 1: sole clock, rising edge.
- `rst` input 1: reset, asynchronous and active-high.
- `pass_i` input 1: level, high once every test has passed.
- `fail_i` input 1: level, high once any test has failed.
- `test_num_i` input 8: index of the failing test.
- `tests_passed_i` input 8: count of passed tests.
- `result_i` input DATA_W: DUT result word of the failing test.
- `golden_i` input DATA_W: expected word of the failing test.
- `uart_tx_o` output 1: serial line, idle high.
- `busy_o` output 1: high while a report is in flight.
- `sent_o` output 1: sticky, high once a report has completed.

## Operation
- Reset state: `uart_tx_o`=1, `busy_o`=0, `sent_o`=0, FSM in IDLE, all counters at 0.
- FSM states are IDLE, CAPTURE, LOAD, SEND, NEXT, DONE.
- **IDLE**: detect a rising edge of `pass_i | fail_i` using a registered previous value that resets to 0. A level already high on the first cycle after reset counts as an edge. On the edge, go to CAPTURE.
- **CAPTURE**: snapshot all four data inputs and the message kind into registers. If `fail_i` and `pass_i` are both high, fail wins. Then go to LOAD.
- **PASS message**: `PASS ` followed by 2 hex digits of tests_passed, then CR LF. Total 9 bytes.
- **FAIL message**: `FAIL `, 2 hex digits of test_num, a space, DATA_W/4 hex digits of result, a space, DATA_W/4 hex digits of golden, then CR LF. Total 27 bytes at DATA_W=32.
- Hex digits are uppercase (`0`–`9`, `A`–`F`) and sent most significant nibble first.
- **LOAD**: combinationally select the byte at `byte_idx`. Pulse `start` to the byte transmitter, then go to SEND.
- **SEND**: wait for the transmitter's `done` pulse, then go to NEXT.
- **NEXT**: if `byte_idx` equals the last index, go to DONE. Otherwise increment `byte_idx` and go to LOAD.
- **DONE**: set `sent_o`=1 and `busy_o`=0. The FSM stays here until reset. There is exactly one report per reset.
- `busy_o` is high in CAPTURE through NEXT.
- Input changes after CAPTURE are ignored.
- Pass/fail edges that arrive while busy or in DONE are ignored.

## Timing
- Edge seen at rising edge N: CAPTURE at N+1, LOAD at N+2. The start bit appears on `uart_tx_o` from N+3.
- Frame: start bit (0), 8 data bits LSB first, stop bit (1). Each bit lasts exactly CLKS_PER_BIT cycles, so a frame is 10·CLKS_PER_BIT cycles.
- The transmitter asserts `done` for 1 cycle at the last cycle of the stop bit.
- The inter-byte gap is 2 cycles (NEXT, LOAD) of idle-high line.
- Total report time = bytes·(10·CLKS_PER_BIT + 2) cycles, ±1 cycle.
- Reset mid-frame forces `uart_tx_o` high asynchronously, with no glitch low. After release the block re-arms in IDLE.
- A 0/1 level on `uart_tx_o` is only ever driven from a register, so the output is glitch-free.

## Structure
- Package `vpu_test_pkg` holds:
  - the FSM state enum `rpt_state_t`;
  - the message-kind enum (MSG_PASS, MSG_FAIL);
  - ASCII constants (CHR_SPACE=8'h20, CHR_CR=8'h0D, CHR_LF=8'h0A);
  - the function `hex_ascii(logic [3:0])`, returning a byte.
- One sub-module, `uart_tx_byte`, with parameter CLKS_PER_BIT. Ports: clk_100mhz, rst, start, data[7:0], tx, busy, done.
- It contains the bit-period counter (0..CLKS_PER_BIT-1) and bit index (0..9).
- Message assembly, the byte index and the FSM live in the top of this block.

## Test plan
Use CLKS_PER_BIT=4 with a bench UART decoder that samples mid-bit.
- **Pass report**: raise `pass_i` with tests_passed=8'h0A → decoded "PASS 0A\r\n", 9 bytes. `busy_o` high throughout; `sent_o`=1 afterwards.
- **Fail report**: `fail_i` with test_num=8'h03, result=32'hDEADBEEF, golden=32'h0000BEEF → decoded "FAIL 03 DEADBEEF 0000BEEF\r\n", 27 bytes.
- **Simultaneous events and latency**: `pass_i` and `fail_i` rising in the same cycle → a FAIL message. The start bit appears exactly 3 cycles after the edge.
- **Input stability and single report**:
  - Change result_i during transmission → the report still shows the captured value.
  - Drop and re-raise `pass_i` after DONE → no second report.
- **Bit timing**: every bit holds for exactly 4 cycles. The gap between a stop bit and the next start bit is 2 cycles. Line idle reads 1.
- **Reset mid-frame**: assert `rst` during byte 5 → `uart_tx_o`=1 immediately. `busy_o`=0 and `sent_o`=0. After release, a new edge gives a complete fresh report.
